// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and wait-state access sequencer in front of a
// single-ported data memory; registered read data with a one-cycle acknowledge.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WAIT     = 2,
  parameter int unsigned MEM_SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                grant1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                last_cycle;

  assign last_cycle = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    // Under contention port 1 wins only when port 0 was granted last.
    grant1    = req1 && (!req0 || !last_grant_q);
    sel_we    = grant1 ? we1    : we0;
    sel_addr  = grant1 ? addr1  : addr0;
    sel_wdata = grant1 ? wdata1 : wdata0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          port_d       = grant1;
          last_grant_d = grant1;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          cnt_d        = '0;
          err_d        = (sel_addr >= ADDR_W'(MEM_SIZE));
          state_d      = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = RESP;
          if (!we_q) begin
            if (port_q) rdata1_d = mem_rdata;
            else        rdata0_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q && last_cycle;
  assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign ack0      = (state_q == RESP) && !port_q;
  assign ack1      = (state_q == RESP) &&  port_q;
  assign err0      = ack0 && err_q;
  assign err1      = ack1 && err_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model with
// per-cycle comparison, directed scenarios and randomized two-port traffic.
module tb_dmem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned WT = 2;
  localparam int unsigned MS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1, mem_read, mem_write, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(WT), .MEM_SIZE(MS)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second instance with a single wait state.
  logic          q_req0 = 1'b0, q_we0 = 1'b0;
  logic [AW-1:0] q_addr0 = '0;
  logic [DW-1:0] q_wdata0 = '0;
  logic          q_ack0, q_ack1, q_err0, q_err1, q_mem_read, q_mem_write, q_busy;
  logic [DW-1:0] q_rdata0, q_rdata1, q_mem_wdata, q_mem_rdata;
  logic [AW-1:0] q_mem_addr;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(1), .MEM_SIZE(MS)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req0(q_req0), .we0(q_we0), .addr0(q_addr0), .wdata0(q_wdata0),
    .ack0(q_ack0), .rdata0(q_rdata0), .err0(q_err0),
    .req1(1'b0), .we1(1'b0), .addr1('0), .wdata1('0),
    .ack1(q_ack1), .rdata1(q_rdata1), .err1(q_err1),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_read(q_mem_read),
    .mem_write(q_mem_write), .mem_rdata(q_mem_rdata), .busy(q_busy)
  );

  // Data memories: synchronous write, combinational read while read is high.
  logic [DW-1:0] mem  [MS];
  logic [DW-1:0] mem1 [MS];
  assign mem_rdata   = mem_read   ? mem[mem_addr[5:0]]    : '0;
  assign q_mem_rdata = q_mem_read ? mem1[q_mem_addr[5:0]] : '0;
  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[5:0]]    <= mem_wdata;
    if (q_mem_write) mem1[q_mem_addr[5:0]] <= q_mem_wdata;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, timed by cycle offsets.
  logic [DW-1:0] ref_mem [MS];
  logic [DW-1:0] m_rdata [2];
  bit            m_active = 1'b0, m_port, m_we, m_oor, m_last = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_start, off;
  bit            e_busy, e_rd, e_wr, e_ack0, e_ack1, e_err0, e_err1, g1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            rd_cnt = 0, wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  int            rd1_cnt = 0, wr1_cnt = 0;

  initial begin
    for (int unsigned i = 0; i < MS; i++) begin
      mem[i]     = 64'h1000 + 64'(i);
      ref_mem[i] = 64'h1000 + 64'(i);
      mem1[i]    = '0;
    end
    mem[5]     = 64'h3;
    ref_mem[5] = 64'h3;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  end

  initial forever begin
    @(negedge clk);
    e_busy = 0; e_rd = 0; e_wr = 0; e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    e_addr = '0; e_wdata = '0; off = 0;
    if (m_active) begin
      off    = cyc - m_start;
      e_busy = 1;
      if (!m_oor && off < int'(WT)) begin
        e_rd    = !m_we;
        e_wr    = m_we && (off == int'(WT) - 1);
        e_addr  = m_addr;
        e_wdata = m_wdata;
      end else begin
        e_ack0 = !m_port;
        e_ack1 = m_port;
        e_err0 = !m_port && m_oor;
        e_err1 = m_port && m_oor;
      end
    end
    if (cyc > 0) begin
      chk("ctrl{busy,rd,wr,ack0,ack1,err0,err1}",
          64'({busy, mem_read, mem_write, ack0, ack1, err0, err1}),
          64'({e_busy, e_rd, e_wr, e_ack0, e_ack1, e_err0, e_err1}));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
    end
    rd_cnt  += int'(mem_read === 1'b1);
    wr_cnt  += int'(mem_write === 1'b1);
    ack0_cnt += int'(ack0 === 1'b1);
    ack1_cnt += int'(ack1 === 1'b1);
    rd1_cnt += int'(q_mem_read === 1'b1);
    wr1_cnt += int'(q_mem_write === 1'b1);
    // Advance the model across the coming edge.
    if (rst) begin
      if (m_active && !m_oor && m_we && off == int'(WT) - 1) ref_mem[m_addr[5:0]] = m_wdata;
      m_active   = 0;
      m_last     = 1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else if (m_active) begin
      if (!m_oor && off == int'(WT) - 1) begin
        if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
        else      m_rdata[m_port] = ref_mem[m_addr[5:0]];
      end
      if (e_ack0 || e_ack1) m_active = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) g1 = !m_last;
      else              g1 = req1;
      m_last   = g1;
      m_port   = g1;
      m_we     = g1 ? we1 : we0;
      m_addr   = g1 ? addr1 : addr0;
      m_wdata  = g1 ? wdata1 : wdata0;
      m_oor    = (m_addr >= 64'(MS));
      m_start  = cyc + 1;
      m_active = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for its ack, then drop the request.
  task automatic txn(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d,
                     output int lat, output bit e);
    int k;
    bit got;
    k = cyc; got = 0; lat = -1; e = 0;
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((p ? ack1 : ack0) === 1'b1) begin
        got = 1;
        lat = cyc - k;
        e   = p ? err1 : err0;
      end
    end
    @(posedge clk); #1;
    if (p) req1 = 0; else req0 = 0;
    if (!got) chk_i("txn_ack_timeout", 0, 1);
  endtask

  function automatic logic [63:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return {32'h1, $urandom};
    if (r < 3)  return 64'(64 + $urandom_range(0, 100));
    return 64'($urandom_range(0, 15));
  endfunction

  int  lat, n, both, t1, t2, base, base2;
  bit  e, a0, a1, got;
  int  order [4];
  int  at [4];
  logic [63:0] saved;

  initial begin
    // Reset state
    step(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack_err", 64'({ack0, ack1, err0, err1}), 64'd0);
    chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    rst = 0;
    step(1);

    base = rd_cnt;
    txn(0, 0, 64'd5, 64'd0, lat, e);
    chk_i("read5_latency", lat, 3);
    chk("read5_rdata0", rdata0, 64'h3);
    chk_i("read5_mem_read_cycles", rd_cnt - base, 2);

    // Write then read
    base = wr_cnt; base2 = ack1_cnt;
    txn(1, 1, 64'd10, 64'hDEAD_BEEF, lat, e);
    chk_i("wr10_mem_write_cycles", wr_cnt - base, 1);
    chk_i("wr10_ack1_pulses", ack1_cnt - base2, 1);
    txn(0, 0, 64'd10, 64'd0, lat, e);
    chk("rd10_rdata0", rdata0, 64'hDEAD_BEEF);
    chk("rd10_rdata1", rdata1, 64'h0);

    // Contention: port 1 granted last so port 0 wins first
    txn(1, 0, 64'd3, 64'd0, lat, e);
    req0 = 1; we0 = 0; addr0 = 64'd1;
    req1 = 1; we1 = 0; addr1 = 64'd2;
    n = 0; both = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1 && ack1 === 1'b1) both++;
      if (ack0 === 1'b1)      begin order[n] = 0; at[n] = cyc; n++; end
      else if (ack1 === 1'b1) begin order[n] = 1; at[n] = cyc; n++; end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    chk_i("cont_ack_count", n, 4);
    chk_i("cont_both_acks", both, 0);
    if (n == 4) begin
      chk_i("cont_order", order[0] * 1000 + order[1] * 100 + order[2] * 10 + order[3], 101);
      for (int i = 0; i < 3; i++) chk_i("cont_spacing", at[i+1] - at[i], int'(WT) + 2);
    end

    // Out of range
    saved = rdata0; base = rd_cnt;
    txn(0, 0, 64'd64, 64'd0, lat, e);
    chk_i("oor_latency", lat, 1);
    chk_i("oor_err0", int'(e), 1);
    chk_i("oor_mem_read_cycles", rd_cnt - base, 0);
    chk("oor_rdata0", rdata0, saved);

    // Reset in the first ACCESS cycle of a read
    rst = 1; step(1); rst = 0;
    chk("rst2_rdata0", rdata0, 64'd0);
    req0 = 1; we0 = 0; addr0 = 64'd7;
    step(1);
    rst = 1;
    step(1);
    rst = 0; req0 = 0;
    chk("midrst_busy", 64'(busy), 64'd0);
    base = ack0_cnt;
    step(5);
    chk_i("midrst_no_ack", ack0_cnt - base, 0);
    chk("midrst_rdata0", rdata0, 64'd0);
    req0 = 1; addr0 = 64'd1; req1 = 1; we1 = 0; addr1 = 64'd2;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        got = 1;
        chk("midrst_first_grant_port0", 64'({ack0, ack1}), 64'b10);
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    if (!got) chk_i("midrst_ack_timeout", 0, 1);
    step(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a0 = (ack0 === 1'b1);
      a1 = (ack1 === 1'b1);
      @(posedge clk); #1;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (!req0 || a0) begin
        req0 = ($urandom_range(0, 2) != 0);
        we0 = 1'($urandom_range(0, 1)); addr0 = rnd_addr(); wdata0 = {$urandom, $urandom};
      end
      if (!req1 || a1) begin
        req1 = ($urandom_range(0, 2) != 0);
        we1 = 1'($urandom_range(0, 1)); addr1 = rnd_addr(); wdata1 = {$urandom, $urandom};
      end
    end
    rst = 0; req0 = 0; req1 = 0;
    step(10);

    // Single wait state: back-to-back write then read of address 0
    base = wr1_cnt; base2 = rd1_cnt;
    t1 = -1; t2 = -1;
    q_req0 = 1; q_we0 = 1; q_addr0 = 64'd0; q_wdata0 = 64'h1234_5678_9ABC_DEF0;
    base = cyc - 0 + 0;
    base = wr1_cnt;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(negedge clk);
      if (q_ack0 === 1'b1) t1 = cyc;
    end
    @(posedge clk); #1;
    q_we0 = 0;
    for (int i = 0; i < 20 && t2 < 0; i++) begin
      @(negedge clk);
      if (q_ack0 === 1'b1) t2 = cyc;
    end
    @(posedge clk); #1;
    q_req0 = 0;
    chk_i("w1_ack_spacing", t2 - t1, 3);
    chk("w1_rdata0", q_rdata0, 64'h1234_5678_9ABC_DEF0);
    chk_i("w1_mem_write_cycles", wr1_cnt - base, 1);
    chk_i("w1_mem_read_cycles", rd1_cnt - base2, 1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported `DataMemory`. It shares the memory between the CPU load/store path (port 0) and a secondary master such as a debug or DMA engine (port 1). It models memory access latency with a programmable wait-state count, generates the memory's `read`/`write` strobes, and returns registered read data with a one-cycle acknowledge. Addresses are word indices, the same addressing the memory uses.

## Interface
- `ADDR_W`, 64, address width (matches the memory address port).
- `DATA_W`, 64, data width.
- `WAIT`, 2, number of ACCESS-state cycles per transaction; legal range 1..15.
- `MEM_SIZE`, 64, number of memory words; any address ≥ `MEM_SIZE` is out of range.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request; held high with its fields stable until `ackN`.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  registered read data; holds its value until the next read on that port completes.
- `err0` / `err1`  out  1  valid with `ackN`; high means the address was out of range.
- `mem_addr`  out  ADDR_W  to `address` of the memory.
- `mem_wdata`  out  DATA_W  to `InData` of the memory.
- `mem_read`  out  1  to `read` of the memory.
- `mem_write`  out  1  to `write` of the memory.
- `mem_rdata`  in  DATA_W  from `outRead` of the memory.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - Sample `req0`/`req1`.
  - With one request, grant it. With both, grant the port that was not granted last (round-robin).
  - `last_grant` resets to 1, so port 0 wins the first contention.
  - On a grant, latch `we`, `addr`, `wdata` and the port id into internal registers, and update `last_grant`.
  - If the address is in range, go to ACCESS with `cnt` = 0.
  - If the address is out of range, go straight to RESP with `err` set. No memory strobe is issued, and `rdata` is left unchanged.
- **ACCESS:**
  - `mem_addr` and `mem_wdata` are driven from the latched registers. They are 0 outside ACCESS.
  - For a read, `mem_read` = 1 for all `WAIT` cycles. At the edge ending the last cycle (`cnt` = `WAIT`-1), `mem_rdata` is captured into `rdata` of the granted port.
  - For a write, `mem_write` = 1 only in the last cycle (`cnt` = `WAIT`-1), so the memory performs exactly one write at that edge.
  - `cnt` increments each cycle. At `cnt` = `WAIT`-1 the next state is RESP.
- **RESP:** `ackN` = 1 for the granted port (and `errN` if flagged) for one cycle, then IDLE.
- **Requester rule:** deassert `req` at the edge that samples `ack`. A `req` still high in the following IDLE cycle is a new transaction.
- Requests arriving while busy are not lost; they wait, held high, until IDLE.
- The other port's `ack`/`err` stay 0 throughout a transaction.
- `mem_read`, `mem_write`, `ack*`, `err*` and `busy` are decoded from registered state and counter only, with no combinational path from `req*`.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `last_grant` 1, `ack0`/`ack1`/`err0`/`err1` 0, `rdata0`/`rdata1` 0, `mem_read`/`mem_write` 0, `mem_addr`/`mem_wdata` 0, `busy` 0.
- **In-range latency:** `req` sampled in IDLE at edge E0, then ACCESS for `WAIT` cycles, then `ack` high in the cycle after edge E0+`WAIT`. Edge-to-ack latency is `WAIT`+1 cycles.
- **Read data:** `rdata` is valid in the same cycle as `ack`.
- **Throughput:** one transaction per `WAIT`+2 cycles, including the IDLE sampling cycle.
- **Out-of-range latency:** `ack` and `err` appear in the cycle after E0.
- **`WAIT` = 1:** a single ACCESS cycle; `mem_read` or `mem_write` is high for exactly one cycle.
- **Reset during ACCESS or RESP:** return to IDLE and suppress any pending `ack`.
  - A write whose last ACCESS cycle coincides with `rst` = 1 still commits in memory at that edge, but it is never acknowledged.
  - Reads cut off by `rst` do not update `rdata`.
- **Simultaneous requests:** port 0 and port 1 alternate strictly on successive grants while both stay asserted.

## Test plan
- **Reset state:** hold `rst` 2 cycles → all outputs 0 and `busy` 0. Then `req0` read of addr 5 with `WAIT` = 2 → `mem_read` high 2 cycles, `ack0` 3 cycles after the sampling edge, `rdata0` = 64'h3 (memory initial content).
- **Write then read:** port 1 writes 64'hDEAD_BEEF to addr 10 → `mem_write` high exactly 1 cycle and `ack1` pulses once. A following port 0 read of addr 10 → `rdata0` = 64'hDEAD_BEEF, and `rdata1` remains 0.
- **Contention:** `req0` and `req1` held continuously for 4 transactions → grant order 0, 1, 0, 1, each `ack` spaced `WAIT`+2 cycles apart, and never both acks in one cycle.
- **Out-of-range:** `req0` read of addr 64 with `MEM_SIZE` = 64 → `ack0` = `err0` = 1 in the cycle after sampling, `mem_read` never asserted, `rdata0` unchanged.
- **Reset mid-read:** assert `rst` in the first ACCESS cycle of a read → no `ack`, state IDLE next cycle, `rdata` unchanged, `last_grant` = 1.
- **`WAIT` = 1 regression:** back-to-back port 0 write then read of addr 0 → `ack` pulses 3 cycles apart, and the read returns the written data.
